// File: rtl/mover_2d_go_ctrl.sv
// mover_2d_go_ctrl: turns a CSR go strobe into one 4-phase req/ack
// handshake and tracks busy, done, timeout and overrun status plus irq.
module mover_2d_go_ctrl #(
  parameter int SYNC_CYCLES = 2,
  parameter int TMO_WIDTH   = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 go,
  input  logic [TMO_WIDTH-1:0] cfg_timeout,
  output logic                 req_out,
  input  logic                 ack_in,
  output logic                 busy,
  output logic                 done_pulse,
  output logic                 sts_done,
  output logic                 sts_tmo,
  output logic                 sts_ovr,
  input  logic                 sts_clr,
  input  logic                 irq_en,
  output logic                 irq
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_REL  = 2'd2
  } state_e;

  state_e               state_q;
  state_e               state_d;
  logic [SYNC_CYCLES:0] ack_sync_q;
  logic [SYNC_CYCLES:0] ack_sync_d;
  logic [TMO_WIDTH-1:0] cnt_q;
  logic [TMO_WIDTH-1:0] cnt_d;
  logic [TMO_WIDTH-1:0] tmo_last;
  logic                 tmo_q;
  logic                 tmo_d;
  logic                 req_q;
  logic                 req_d;
  logic                 done_q;
  logic                 done_d;
  logic                 sdone_q;
  logic                 sdone_d;
  logic                 stmo_q;
  logic                 stmo_d;
  logic                 sovr_q;
  logic                 sovr_d;
  logic                 irq_q;
  logic                 irq_d;
  logic                 ack_s;
  logic                 launch;
  logic                 tmo_hit;
  logic                 rel_exit;
  logic                 clr;

  assign ack_sync_d = {ack_sync_q[SYNC_CYCLES-1:0], ack_in};
  assign ack_s      = ack_sync_q[SYNC_CYCLES];

  assign tmo_last = cfg_timeout - TMO_WIDTH'(1);
  assign tmo_hit  = (cfg_timeout != '0) && (cnt_q == tmo_last);
  assign launch   = (state_q == ST_IDLE) && go;
  assign rel_exit = (state_q == ST_REL) && !ack_s;
  assign clr      = sts_clr || launch;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      ack_sync_q <= '0;
      cnt_q      <= '0;
      tmo_q      <= 1'b0;
      req_q      <= 1'b0;
      done_q     <= 1'b0;
      sdone_q    <= 1'b0;
      stmo_q     <= 1'b0;
      sovr_q     <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      ack_sync_q <= ack_sync_d;
      cnt_q      <= cnt_d;
      tmo_q      <= tmo_d;
      req_q      <= req_d;
      done_q     <= done_d;
      sdone_q    <= sdone_d;
      stmo_q     <= stmo_d;
      sovr_q     <= sovr_d;
      irq_q      <= irq_d;
    end
  end

  // ack beats a timeout landing in the same REQ cycle
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (go) state_d = ST_REQ;
      ST_REQ:  if (ack_s || tmo_hit) state_d = ST_REL;
      ST_REL:  if (!ack_s) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    tmo_d = tmo_q;
    if (launch) begin
      cnt_d = '0;
    end else if ((state_q == ST_REQ) && (cnt_q != '1)) begin
      cnt_d = cnt_q + TMO_WIDTH'(1);
    end
    if (state_q == ST_REQ) begin
      tmo_d = !ack_s && tmo_hit;
    end
    req_d   = (state_d == ST_REQ);
    done_d  = rel_exit && !tmo_q;
    // a set event in the same cycle as a clear leaves the flag set
    sdone_d = done_d || (sdone_q && !clr);
    stmo_d  = (rel_exit && tmo_q) || (stmo_q && !clr);
    sovr_d  = (go && (state_q != ST_IDLE)) || (sovr_q && !clr);
    irq_d   = irq_en && (sdone_d || stmo_d || sovr_d);
  end

  assign req_out    = req_q;
  assign busy       = (state_q != ST_IDLE);
  assign done_pulse = done_q;
  assign sts_done   = sdone_q;
  assign sts_tmo    = stmo_q;
  assign sts_ovr    = sovr_q;
  assign irq        = irq_q;

endmodule

// File: tb/tb_mover_2d_go_ctrl.sv
// Bench for mover_2d_go_ctrl: three instances (sync depth 2, 1, 4) with
// per-instance engine emulators, a behavioural model and directed checks.
module tb_mover_2d_go_ctrl;

  localparam int TW = 16;
  localparam int SDV [3] = '{2, 1, 4};
  localparam int BASIC_LEN [3] = '{9, 8, 11};
  localparam int RACE_LEN [3] = '{8, 7, 8};
  localparam int RACE_DONE [3] = '{1, 1, 0};
  localparam int RACE_TMO [3] = '{0, 0, 1};

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          go = 1'b0;
  logic [TW-1:0] cfg_timeout = '0;
  logic          sts_clr = 1'b0;
  logic          irq_en = 1'b0;

  wire [2:0] ack_w;
  wire [2:0] req_w;
  wire [2:0] busy_w;
  wire [2:0] dp_w;
  wire [2:0] sd_w;
  wire [2:0] st_w;
  wire [2:0] so_w;
  wire [2:0] irq_w;

  int eng_d = 5;
  int eng_r = 4;
  int eng_dmax = 0;
  int eng_rmax = 0;
  bit eng_rand = 1'b0;
  bit eng_never = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;
  bit cmp_on = 1'b0;

  int rl [3];
  int dn [3];
  int rq [3];
  int br [3];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : u
    localparam int SC = (g == 0) ? 2 : ((g == 1) ? 1 : 4);
    logic ack;
    int   dd;
    int   rr;
    bit   nev;

    assign ack_w[g] = ack;

    mover_2d_go_ctrl #(
      .SYNC_CYCLES(SC),
      .TMO_WIDTH  (TW)
    ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .go         (go),
      .cfg_timeout(cfg_timeout),
      .req_out    (req_w[g]),
      .ack_in     (ack),
      .busy       (busy_w[g]),
      .done_pulse (dp_w[g]),
      .sts_done   (sd_w[g]),
      .sts_tmo    (st_w[g]),
      .sts_ovr    (so_w[g]),
      .sts_clr    (sts_clr),
      .irq_en     (irq_en),
      .irq        (irq_w[g])
    );

    // engine: ack some cycles after seeing req, drop after req falls
    initial begin
      ack = 1'b0;
      forever begin
        do @(negedge clk); while (req_w[g] !== 1'b1);
        nev = eng_never;
        dd = eng_rand ? int'($urandom_range(0, eng_dmax)) : eng_d;
        rr = eng_rand ? int'($urandom_range(0, eng_rmax)) : eng_r;
        if (!nev) begin
          repeat (dd) @(posedge clk);
          #3 ack = 1'b1;
        end
        while (req_w[g] === 1'b1) @(negedge clk);
        repeat (rr) @(posedge clk);
        #3 ack = 1'b0;
      end
    end
  end

  // behavioural model: phase 0=idle 1=req 2=release
  int        ph [3];
  int        age [3];
  bit        mt [3];
  bit [15:0] hist [3];
  bit        sd [3];
  bit        st [3];
  bit        so [3];
  bit        mdp [3];
  bit        mirq [3];

  int        n_ph [3];
  int        n_age [3];
  bit        n_mt [3];
  bit [15:0] n_hist [3];
  bit        n_sd [3];
  bit        n_st [3];
  bit        n_so [3];
  bit        n_dp [3];
  bit        n_irq [3];
  bit        acks [3];
  bit        edn [3];
  bit        etm [3];
  bit        eov [3];
  bit        clrv [3];

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      acks[i]   = hist[i][SDV[i]];
      n_hist[i] = {hist[i][14:0], ack_w[i]};
      n_ph[i]   = ph[i];
      n_age[i]  = age[i];
      n_mt[i]   = mt[i];
      edn[i]    = 1'b0;
      etm[i]    = 1'b0;
      eov[i]    = 1'b0;
      clrv[i]   = sts_clr;
      if (ph[i] == 0) begin
        if (go) begin
          n_ph[i]  = 1;
          n_age[i] = 0;
          clrv[i]  = 1'b1;
        end
      end else if (ph[i] == 1) begin
        eov[i] = go;
        if (acks[i]) begin
          n_ph[i] = 2;
          n_mt[i] = 1'b0;
        end else if ((cfg_timeout != 0) && (age[i] + 1 == int'(cfg_timeout))) begin
          n_ph[i] = 2;
          n_mt[i] = 1'b1;
        end
        n_age[i] = age[i] + 1;
      end else begin
        eov[i] = go;
        if (!acks[i]) begin
          n_ph[i] = 0;
          edn[i]  = !mt[i];
          etm[i]  = mt[i];
        end
      end
      n_dp[i]  = edn[i];
      n_sd[i]  = edn[i] || (sd[i] && !clrv[i]);
      n_st[i]  = etm[i] || (st[i] && !clrv[i]);
      n_so[i]  = eov[i] || (so[i] && !clrv[i]);
      n_irq[i] = irq_en && (n_sd[i] || n_st[i] || n_so[i]);
    end
  end

  always @(posedge clk or negedge reset_n) begin
    for (int i = 0; i < 3; i++) begin
      if (!reset_n) begin
        ph[i]   <= 0;
        age[i]  <= 0;
        mt[i]   <= 1'b0;
        hist[i] <= '0;
        sd[i]   <= 1'b0;
        st[i]   <= 1'b0;
        so[i]   <= 1'b0;
        mdp[i]  <= 1'b0;
        mirq[i] <= 1'b0;
      end else begin
        ph[i]   <= n_ph[i];
        age[i]  <= n_age[i];
        mt[i]   <= n_mt[i];
        hist[i] <= n_hist[i];
        sd[i]   <= n_sd[i];
        st[i]   <= n_st[i];
        so[i]   <= n_so[i];
        mdp[i]  <= n_dp[i];
        mirq[i] <= n_irq[i];
      end
    end
  end

  task automatic cmp_loop();
    logic [6:0] exp_v;
    logic [6:0] act_v;
    forever begin
      @(negedge clk);
      if (cmp_on) begin
        for (int i = 0; i < 3; i++) begin
          exp_v = {ph[i] == 1, ph[i] != 0, mdp[i], sd[i], st[i], so[i], mirq[i]};
          act_v = {req_w[i], busy_w[i], dp_w[i], sd_w[i], st_w[i], so_w[i], irq_w[i]};
          n_cmp++;
          if (act_v !== exp_v) begin
            n_bad++;
            $display("FAIL model inst%0d t=%0t: got %b required %b (req busy dp done tmo ovr irq)",
                     i, $time, act_v, exp_v);
          end
        end
      end
    end
  endtask

  task automatic chk(input string nm, input int act, input int exp_v);
    n_cmp++;
    if (act != exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0d required %0d", nm, act, exp_v);
    end
  endtask

  task automatic pulse_go();
    @(posedge clk);
    #2 go = 1'b1;
    @(posedge clk);
    #2 go = 1'b0;
  endtask

  task automatic watch(input int ncyc, input int ga, input int gb);
    bit pr [3];
    bit pb [3];
    for (int i = 0; i < 3; i++) begin
      rl[i] = 0;
      dn[i] = 0;
      rq[i] = 0;
      br[i] = 0;
      pr[i] = 1'b0;
      pb[i] = 1'b0;
    end
    for (int k = 1; k <= ncyc; k++) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        rl[i] += int'(req_w[i]);
        dn[i] += int'(dp_w[i]);
        if (req_w[i] && !pr[i]) rq[i]++;
        if (busy_w[i] && !pb[i]) br[i]++;
        pr[i] = req_w[i];
        pb[i] = busy_w[i];
      end
      #1 go = (k == ga) || (k == gb);
    end
    #1 go = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int k;
    k = 0;
    while ((busy_w !== 3'b000) && (k < 3000)) begin
      @(negedge clk);
      k++;
    end
    chk(nm, int'(k < 3000), 1);
  endtask

  initial begin
    int n;
    fork
      cmp_loop();
    join_none

    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_req", int'(req_w), 0);
    chk("rst_busy", int'(busy_w), 0);
    chk("rst_flags", int'({sd_w, st_w, so_w, dp_w}), 0);
    chk("rst_irq", int'(irq_w), 0);
    cmp_on = 1'b1;
    reset_n = 1'b1;
    repeat (3) @(posedge clk);

    // basic launch
    irq_en = 1'b1;
    cfg_timeout = '0;
    eng_d = 5;
    eng_r = 4;
    pulse_go();
    watch(60, 0, 0);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("basic_len%0d", i), rl[i], BASIC_LEN[i]);
      chk($sformatf("basic_done_pulses%0d", i), dn[i], 1);
      chk($sformatf("basic_sts_done%0d", i), int'(sd_w[i]), 1);
      chk($sformatf("basic_irq%0d", i), int'(irq_w[i]), 1);
    end

    // timeout with a silent engine
    cfg_timeout = TW'(10);
    eng_never = 1'b1;
    pulse_go();
    watch(40, 0, 0);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("tmo_len%0d", i), rl[i], 10);
      chk($sformatf("tmo_done_pulses%0d", i), dn[i], 0);
      chk($sformatf("tmo_sts_tmo%0d", i), int'(st_w[i]), 1);
      chk($sformatf("tmo_sts_done%0d", i), int'(sd_w[i]), 0);
    end
    chk("tmo_idle", int'(busy_w), 0);

    // ack and timeout race
    eng_never = 1'b0;
    eng_d = 4;
    cfg_timeout = TW'(8);
    pulse_go();
    watch(60, 0, 0);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("race_len%0d", i), rl[i], RACE_LEN[i]);
      chk($sformatf("race_done%0d", i), int'(sd_w[i]), RACE_DONE[i]);
      chk($sformatf("race_tmo%0d", i), int'(st_w[i]), RACE_TMO[i]);
    end

    // overrun: go during REQ and during REL
    cfg_timeout = '0;
    eng_d = 5;
    pulse_go();
    watch(60, 3, 12);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("ovr_flag%0d", i), int'(so_w[i]), 1);
      chk($sformatf("ovr_req_rises%0d", i), rq[i], 1);
      chk($sformatf("ovr_busy_rises%0d", i), br[i], 1);
      chk($sformatf("ovr_done_pulses%0d", i), dn[i], 1);
    end
    chk("ovr_irq_before_clr", int'(irq_w), 7);
    @(posedge clk);
    #2 sts_clr = 1'b1;
    @(posedge clk);
    #2 sts_clr = 1'b0;
    chk("clr_flags", int'({sd_w, st_w, so_w}), 0);
    chk("clr_irq", int'(irq_w), 0);

    // async reset in the middle of REQ
    pulse_go();
    repeat (3) @(negedge clk);
    #1 go = 1'b1;
    @(negedge clk);
    #1 go = 1'b0;
    @(negedge clk);
    chk("pre_rst_req", int'(req_w), 7);
    chk("pre_rst_irq", int'(irq_w), 7);
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst_req", int'(req_w), 0);
    chk("async_rst_busy", int'(busy_w), 0);
    chk("async_rst_irq", int'(irq_w), 0);
    repeat (3) @(negedge clk);
    #2 reset_n = 1'b1;
    repeat (30) @(posedge clk);
    pulse_go();
    watch(60, 0, 0);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("post_rst_len%0d", i), rl[i], BASIC_LEN[i]);
      chk($sformatf("post_rst_done%0d", i), int'(sd_w[i]), 1);
    end

    // randomized traffic
    eng_rand = 1'b1;
    for (int s = 0; s < 40; s++) begin
      @(posedge clk);
      #2;
      cfg_timeout = ($urandom_range(0, 3) == 0) ? TW'(0) : TW'($urandom_range(1, 30));
      eng_dmax = int'($urandom_range(0, 25));
      eng_rmax = int'($urandom_range(0, 8));
      eng_never = (cfg_timeout != 0) && ($urandom_range(0, 3) == 0);
      irq_en = 1'($urandom_range(0, 1));
      n = int'($urandom_range(40, 150));
      for (int c = 0; c < n; c++) begin
        @(posedge clk);
        #2;
        go = ($urandom_range(0, 7) == 0);
        sts_clr = ($urandom_range(0, 11) == 0);
        if ($urandom_range(0, 19) == 0) irq_en = ~irq_en;
      end
      @(posedge clk);
      #2;
      go = 1'b0;
      sts_clr = 1'b0;
      wait_idle($sformatf("rand_idle%0d", s));
    end

    repeat (5) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
